// File: rtl/mult_rr_scheduler.sv
// rtl/mult_rr_scheduler.sv - round-robin shared shift-add unsigned multiplier
//
// Purpose:
//   NREQ requesters share one sequential shift-add multiplier. A round-robin
//   arbiter picks one pending requester, latches its operands and runs the
//   multiply for WIDTH cycles. The product comes back tagged with the
//   requester's index.
//
// Ports:
//   CLK            in   1            rising-edge clock
//   RST            in   1            asynchronous active-high reset
//   req            in   NREQ         req[i]=1: requester i wants a multiply
//   in_a           in   NREQ*WIDTH   multiplicands, slice i = in_a[i*WIDTH +: WIDTH]
//   in_b           in   NREQ*WIDTH   multipliers, same slicing
//   gnt            out  NREQ         one-hot single-cycle pulse: operands of i taken
//   busy           out  1            high while a multiply is running
//   Product        out  2*WIDTH      result, held until the next grant
//   Product_Valid  out  1            single-cycle pulse: Product/Product_Id valid
//   Product_Id     out  IDW          requester index that owns Product

module mult_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   in_a,
   input  logic [NREQ*WIDTH-1:0]   in_b,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   output logic [2*WIDTH-1:0]      Product,
   output logic                    Product_Valid,
   output logic [IDW-1:0]          Product_Id
);

   // Step counter only needs to reach WIDTH-1; the last step is detected by compare.
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state;
   logic [IDW-1:0]      last;
   logic [SW-1:0]       step;
   logic [WIDTH-1:0]    mplicand;

   // ------------------------------------------------------------------
   // Round-robin winner selection.
   // The request vector is rotated so that index last+1 sits at bit 0;
   // the lowest set bit of the rotated vector is then the winner's offset
   // from last+1. NREQ is a power of two, so IDW-bit adds wrap mod NREQ.
   // ------------------------------------------------------------------
   logic [IDW-1:0]      start;
   logic [2*NREQ-1:0]   req_dbl;
   logic [2*NREQ-1:0]   req_rot_full;
   logic [NREQ-1:0]     req_rot;
   logic [IDW-1:0]      win_off;
   logic [IDW-1:0]      winner;

   always_comb begin
      start        = last + IDW'(1);
      req_dbl      = {req, req};
      req_rot_full = req_dbl >> start;
      req_rot      = req_rot_full[NREQ-1:0];
      win_off      = '0;
      // Scan downward so the lowest set bit is the one that sticks.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_off = IDW'(i);
         end
      end
      winner = start + win_off;
   end

   // Operands of the current winner.
   logic [WIDTH-1:0]    a_sel;
   logic [WIDTH-1:0]    b_sel;

   always_comb begin
      a_sel = in_a[winner*WIDTH +: WIDTH];
      b_sel = in_b[winner*WIDTH +: WIDTH];
   end

   // ------------------------------------------------------------------
   // One shift-add step. Product holds {partial sum, remaining multiplier}.
   // The add is one bit wider than Product so the carry out of the upper
   // half is not lost; after the right shift it lands in Product's MSB.
   // ------------------------------------------------------------------
   logic [2*WIDTH:0]    sum;
   logic [2*WIDTH-1:0]  prod_next;

   always_comb begin
      sum = {1'b0, mplicand, {WIDTH{1'b0}}} + {1'b0, Product};
      if (Product[0]) begin
         prod_next = sum[2*WIDTH:1];
      end else begin
         prod_next = {1'b0, Product[2*WIDTH-1:1]};
      end
   end

   // ------------------------------------------------------------------
   // Control FSM with registered outputs.
   // Product_Valid is only set on the final RUN edge, so the IDLE cycle in
   // which it is high can already arbitrate and grant the next requester.
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= IDLE;
         gnt           <= '0;
         busy          <= 1'b0;
         Product       <= '0;
         Product_Valid <= 1'b0;
         Product_Id    <= '0;
         step          <= '0;
         mplicand      <= '0;
         // Pointer at NREQ-1 makes requester 0 the first to be searched.
         last          <= IDW'(NREQ - 1);
      end else begin
         gnt           <= '0;
         Product_Valid <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt        <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                  last       <= winner;
                  Product_Id <= winner;
                  mplicand   <= a_sel;
                  Product    <= {{WIDTH{1'b0}}, b_sel};
                  step       <= '0;
                  busy       <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               // Requests and operand inputs are deliberately ignored here.
               Product <= prod_next;
               step    <= step + SW'(1);
               if (step == SW'(WIDTH - 1)) begin
                  Product_Valid <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
